// File: rtl/fifo_word_packer.sv
// Packs Lanes consecutive FIFO bytes into one wide word behind a valid/ready handshake.
// Optional stall counter output enabled by defining PACKER_STALL_CNT_EN.
module fifo_word_packer #(
  parameter int Width = 8,
  parameter int Lanes = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     empty_flag_i,
  output logic                     read_o,
  input  logic [Width-1:0]         r_data_i,
  input  logic                     flush_i,
  output logic [Width*Lanes-1:0]   word_o,
  output logic [Lanes-1:0]         byte_en_o,
  output logic                     valid_o,
  input  logic                     ready_i
`ifdef PACKER_STALL_CNT_EN
  ,
  output logic [15:0]              stall_cnt_o
`endif
);

  // state | meaning
  // FILL  | popping bytes from the FIFO into lanes
  // HOLD  | word presented, waiting for ready_i
  localparam int CntW = $clog2(Lanes + 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [CntW-1:0]          lane_cnt;
  logic                     pending;
  logic                     flush_pend;
  logic [Width*Lanes-1:0]   word_q;
  logic [Lanes-1:0]         be_q;
  logic [CntW:0]            fill_level;
  logic                     last_capture;
  logic                     flush_done;
  logic                     handshake;
  logic                     flush_take;

  // In-flight reads count against capacity so the word can never overflow
  assign fill_level   = {1'b0, lane_cnt} + {{CntW{1'b0}}, pending};
  assign last_capture = pending && (lane_cnt == CntW'(Lanes - 1));
  assign flush_done   = flush_pend && !pending && (lane_cnt != '0);
  assign handshake    = (state == HOLD) && ready_i;
  assign flush_take   = (state == FILL) && flush_i && ((lane_cnt != '0) || pending);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= FILL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (last_capture || flush_done) state_nxt = HOLD;
      HOLD:    if (ready_i) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_comb begin
    read_o  = !rst_i && (state == FILL) && !empty_flag_i && !flush_pend &&
              (fill_level < (CntW + 1)'(Lanes));
    valid_o = (state == HOLD);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lane_cnt   <= '0;
      pending    <= 1'b0;
      flush_pend <= 1'b0;
      word_q     <= '0;
      be_q       <= '0;
    end else begin
      pending <= read_o;
      if (handshake) begin
        lane_cnt   <= '0;
        flush_pend <= 1'b0;
        word_q     <= '0;
        be_q       <= '0;
      end else begin
        if (pending) begin
          for (int k = 0; k < Lanes; k++) begin
            if (lane_cnt == CntW'(k)) begin
              word_q[k*Width +: Width] <= r_data_i;
              be_q[k]                  <= 1'b1;
            end
          end
          lane_cnt <= lane_cnt + CntW'(1);
        end
        if (flush_take) flush_pend <= 1'b1;
      end
    end
  end

  assign word_o    = word_q;
  assign byte_en_o = be_q;

`ifdef PACKER_STALL_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      stall_cnt_o <= 16'd0;
    else if (valid_o && !ready_i && (stall_cnt_o != 16'hFFFF))
      stall_cnt_o <= stall_cnt_o + 16'd1;
  end
`endif

endmodule
